// File: rtl/bcd_counter_slow.sv
// bcd_counter_slow: multi-digit up/down BCD counter advanced by a slow-tick strobe
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high clear of all digits
//   slowena   count strobe; one step per clk edge while high
//   up_dn     1 = count up, 0 = count down
//   load      synchronous parallel load (digits >9 stored as 9)
//   load_val  BCD load value, digit i = load_val[4i+3:4i]
//   q         current count, digit 0 least significant
//   tc        combinational terminal count, meant as slowena of a next stage
//
// Build option: define BCDC_SATURATE_EN to hold at 9..9 / 0..0 instead of wrapping.
module bcd_counter_slow #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slowena,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc
);
    // ripple[i] is high when every digit below i sits at its wrap value,
    // so digit i steps on this edge; ripple[DIGITS] flags the whole counter at its end
    logic [DIGITS:0]       ripple;
    logic [4*DIGITS-1:0]   load_clamped;
    logic [4*DIGITS-1:0]   stepped;
    logic                  hold_end;

    assign ripple[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        logic [3:0] lv;
        assign d  = q[4*i +: 4];
        assign lv = load_val[4*i +: 4];
        assign load_clamped[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
        assign ripple[i+1] = ripple[i] & (up_dn ? (d == 4'd9) : (d == 4'd0));
        assign stepped[4*i +: 4] = !ripple[i] ? d :
                                   up_dn ? ((d == 4'd9) ? 4'd0 : d + 4'd1) :
                                           ((d == 4'd0) ? 4'd9 : d - 4'd1);
    end

    assign tc = slowena & ripple[DIGITS];

`ifdef BCDC_SATURATE_EN
    assign hold_end = ripple[DIGITS];
`else
    assign hold_end = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_clamped;
        else if (slowena && !hold_end)
            q <= stepped;
    end
endmodule

// File: tb/tb_bcd_counter_slow.sv
// tb_bcd_counter_slow: directed vector table on a 2-digit counter plus a randomised 3-digit run against an integer model
module tb_bcd_counter_slow;
`ifdef BCDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, slowena, up_dn, load;
    logic [7:0]  load_val;
    logic [7:0]  q;
    logic        tc;
    logic        reset3, slowena3, up_dn3, load3;
    logic [11:0] load_val3;
    logic [11:0] q3;
    logic        tc3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_counter_slow #(.DIGITS(2)) dut (
        .clk(clk), .reset(reset), .slowena(slowena), .up_dn(up_dn),
        .load(load), .load_val(load_val), .q(q), .tc(tc)
    );

    bcd_counter_slow #(.DIGITS(3)) dut3 (
        .clk(clk), .reset(reset3), .slowena(slowena3), .up_dn(up_dn3),
        .load(load3), .load_val(load_val3), .q(q3), .tc(tc3)
    );

    typedef struct {
        bit         rst;
        bit         en;
        bit         up;
        bit         ld;
        logic [7:0] lv;
        bit         exp_tc;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vt[64];
    int   nv = 0;

    task automatic add(input bit rst, input bit en, input bit up, input bit ld,
                       input logic [7:0] lv, input bit etc, input logic [7:0] eq);
        vt[nv] = '{rst, en, up, ld, lv, etc, eq};
        nv++;
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int m);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic int clamp_val(input logic [11:0] v);
        int d2, d1, d0;
        d2 = (v[11:8] > 9) ? 9 : int'(v[11:8]);
        d1 = (v[7:4] > 9) ? 9 : int'(v[7:4]);
        d0 = (v[3:0] > 9) ? 9 : int'(v[3:0]);
        return d2 * 100 + d1 * 10 + d0;
    endfunction

    initial begin
        int  m;
        bit  valid;
        reset = 0; slowena = 0; up_dn = 1; load = 0; load_val = 8'h00;
        reset3 = 0; slowena3 = 0; up_dn3 = 1; load3 = 0; load_val3 = 12'h000;

        // rst en up ld  lv     tc  q-after
        add(1, 0, 1, 0, 8'h00, 0, 8'h00);
        for (int k = 1; k <= 12; k++)
            add(0, 1, 1, 0, 8'h00, 0, 8'((k / 10) * 16 + k % 10));
        add(0, 0, 1, 1, 8'h98, 0, 8'h98);
        add(0, 1, 1, 0, 8'h00, 0, 8'h99);
        add(0, 1, 1, 0, 8'h00, 1, SAT ? 8'h99 : 8'h00);
        add(0, 0, 0, 1, 8'h10, 0, 8'h10);
        add(0, 1, 0, 0, 8'h00, 0, 8'h09);
        add(0, 1, 0, 0, 8'h00, 0, 8'h08);
        add(0, 0, 0, 1, 8'h00, 0, 8'h00);
        add(0, 1, 0, 0, 8'h00, 1, SAT ? 8'h00 : 8'h99);
        add(0, 0, 1, 1, 8'h09, 0, 8'h09);
        add(0, 0, 1, 0, 8'h00, 0, 8'h09);
        add(0, 0, 0, 0, 8'h00, 0, 8'h09);
        add(0, 0, 1, 0, 8'h00, 0, 8'h09);
        add(0, 1, 1, 0, 8'h00, 0, 8'h10);
        add(0, 1, 1, 1, 8'hAF, 0, 8'h99);
        add(0, 1, 1, 1, 8'hAF, 1, 8'h99);
        add(1, 1, 1, 1, 8'h55, 1, 8'h00);
        add(0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 1, 8'hA5, 0, 8'h95);
        add(0, 1, 0, 0, 8'h00, 0, 8'h94);
        add(0, 0, 1, 1, 8'h3C, 0, 8'h39);
        add(0, 1, 1, 0, 8'h00, 0, 8'h40);
        add(1, 0, 0, 0, 8'h00, 0, 8'h00);
        add(0, 1, 0, 0, 8'h00, 1, SAT ? 8'h00 : 8'h99);

        for (int i = 0; i < nv; i++) begin
            reset = vt[i].rst; slowena = vt[i].en; up_dn = vt[i].up;
            load = vt[i].ld; load_val = vt[i].lv;
            #1;
            chk("tc", i, 16'(tc), 16'(vt[i].exp_tc));
            @(posedge clk);
            #1;
            chk("q", i, 16'(q), 16'(vt[i].exp_q));
        end
        reset = 0; slowena = 0; load = 0;

        // randomised 3-digit run against an integer model of the count
        m = 0;
        valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset3    = (c == 0) || ($urandom_range(31) == 0);
            load3     = ($urandom_range(7) == 0);
            slowena3  = ($urandom_range(3) != 0);
            up_dn3    = $urandom_range(1);
            load_val3 = 12'($urandom);
            #1;
            if (valid)
                chk("tc3", c, 16'(tc3), 16'(slowena3 && (up_dn3 ? (m == 999) : (m == 0))));
            @(posedge clk);
            if (reset3)
                m = 0;
            else if (load3)
                m = clamp_val(load_val3);
            else if (slowena3) begin
                if (up_dn3)
                    m = (m == 999) ? (SAT ? 999 : 0) : m + 1;
                else
                    m = (m == 0) ? (SAT ? 0 : 999) : m - 1;
            end
            valid = valid | reset3;
            #1;
            if (valid)
                chk("q3", c, 16'(q3), 16'(to_bcd(m)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
